// File: rtl/memory_arbiter.sv
// memory_arbiter: serializes instruction-fetch and data-access requests onto a
// single RAM port. Data requests win over fetches. Each transaction ends with a
// one-cycle ihit/dhit pulse, and read data is held in iload/dload.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, a transaction whose RAM never reports ACCESS is aborted after
//   TIMEOUT wait cycles. The pending hit still pulses, the load register gets
//   zero (a write leaves dload alone) and the sticky timeout output is set.
//   When undefined, the arbiter waits indefinitely and has no timeout port.
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; arbitrate live requests, data first
// IFETCH  | instruction read on the RAM port, waiting for ACCESS
// DACCESS | data read or write on the RAM port, waiting for ACCESS
// RESP    | enables low, ihit or dhit high for this one cycle

module memory_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic [31:0] iload,
    output logic        ihit,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic [31:0] dload,
    output logic        dhit,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
`ifdef ARB_TIMEOUT_EN
    ,
    output logic        timeout
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] IFETCH  = 2'd1;
    localparam logic [1:0] DACCESS = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    localparam logic [1:0] RAM_FREE   = 2'd0;
    localparam logic [1:0] RAM_BUSY   = 2'd1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    // Reject out-of-range timeouts at elaboration rather than silently wrapping
    // the 10-bit wait counter.
    if (TIMEOUT < 2 || TIMEOUT > 1023) begin : g_bad_timeout
        $error("memory_arbiter: TIMEOUT must be in 2..1023");
    end

    logic [1:0] state;
    logic       is_write;
    logic       waiting;
    logic       ram_ready;
    logic       expire;
    logic       done;

    // ACCESS is the only RAM status that completes a transfer; FREE, BUSY and
    // ERROR all mean keep the request on the port and wait.
    assign waiting   = (state == IFETCH) || (state == DACCESS);
    assign ram_ready = (ramstate == RAM_ACCESS);

`ifdef ARB_TIMEOUT_EN
    localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT - 1);

    logic [9:0] wait_cnt;

    // Abort on the wait cycle where the counter reaches TIMEOUT-1 with no ACCESS,
    // so the transaction spends exactly TIMEOUT cycles waiting.
    assign expire = waiting && !ram_ready && (wait_cnt == TIMEOUT_LAST);

    // Wait-cycle counter: held at zero while idle so every grant starts fresh.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_cnt <= '0;
        end else if (!waiting) begin
            wait_cnt <= '0;
        end else if (!ram_ready && !expire) begin
            wait_cnt <= wait_cnt + 10'd1;
        end
    end

    // Sticky abort flag; only reset clears it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timeout <= 1'b0;
        end else if (expire) begin
            timeout <= 1'b1;
        end
    end
`else
    assign expire = 1'b0;
`endif

    assign done = ram_ready || expire;

    // Arbitration FSM; every output is a register so the RAM and requester see
    // clean, glitch-free signals. Address and store data are captured at grant
    // and held afterwards, so live request inputs do not disturb a transfer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            is_write <= 1'b0;
            ihit     <= 1'b0;
            dhit     <= 1'b0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            iload    <= '0;
            dload    <= '0;
        end else begin
            ihit <= 1'b0;
            dhit <= 1'b0;
            case (state)
                IDLE: begin
                    if (dmemREN || dmemWEN) begin
                        // A simultaneous read and write request is treated as a write.
                        state    <= DACCESS;
                        is_write <= dmemWEN;
                        ramaddr  <= dmemaddr;
                        ramstore <= dmemstore;
                        ramWEN   <= dmemWEN;
                        ramREN   <= !dmemWEN;
                    end else if (imemREN) begin
                        state    <= IFETCH;
                        is_write <= 1'b0;
                        ramaddr  <= imemaddr;
                        ramREN   <= 1'b1;
                    end
                end
                IFETCH: begin
                    if (done) begin
                        state  <= RESP;
                        ramREN <= 1'b0;
                        ihit   <= 1'b1;
                        iload  <= ram_ready ? ramload : 32'h0;
                    end
                end
                DACCESS: begin
                    if (done) begin
                        state  <= RESP;
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        dhit   <= 1'b1;
                        if (!is_write) begin
                            dload <= ram_ready ? ramload : 32'h0;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    ramREN <= 1'b0;
                    ramWEN <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Structural invariants of the port protocol.
    a_one_hit : assert property (@(posedge CLK) disable iff (RST) !(ihit && dhit));
    a_one_en  : assert property (@(posedge CLK) disable iff (RST) !(ramREN && ramWEN));
    a_hit_len : assert property (@(posedge CLK) disable iff (RST) (ihit || dhit) |=> !(ihit || dhit));
`endif

    // Unused encodings are named for readability of the status decode only.
    logic unused_codes;
    assign unused_codes = ^{RAM_FREE, RAM_BUSY, RAM_ERROR};

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Sequential arbiter between the request unit and the single-port RAM model. Accepts the instruction-fetch and data-access requests the request unit drives (imemREN, dmemREN, dmemWEN), serializes them onto one RAM port with data priority, and returns one-cycle ihit/dhit pulses with latched load data. Sits directly downstream of the request unit and upstream of the RAM.

## Interface
Parameters:
- TIMEOUT, 64, RAM wait cycles before a transaction is aborted. Used only when the timeout feature is compiled in; legal range 2..1023.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- imemREN  in  1  instruction read request
- imemaddr  in  32  instruction word address
- iload  out  32  fetched instruction, latched
- ihit  out  1  instruction complete, one-cycle pulse
- dmemREN  in  1  data read request
- dmemWEN  in  1  data write request
- dmemaddr  in  32  data address
- dmemstore  in  32  write data
- dload  out  32  read data, latched
- dhit  out  1  data complete, one-cycle pulse
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- timeout  out  1  sticky abort flag, present only with ARB_TIMEOUT_EN

## Operation
- States: IDLE, IFETCH, DACCESS, RESP.
- IDLE: if dmemREN|dmemWEN -> DACCESS; else if imemREN -> IFETCH; else stay. On transition, latch address, store data and a write flag (dmemWEN wins if both dmemREN and dmemWEN are high).
- IFETCH/DACCESS: drive ramREN/ramWEN, ramaddr, ramstore from latched registers only; live request inputs are ignored. BUSY, FREE and ERROR all mean wait and keep driving. On ramstate==ACCESS: capture ramload into iload (IFETCH) or dload (DACCESS read; dload unchanged on write), go to RESP.
- RESP: ram enables low; ihit or dhit high for exactly this cycle; -> IDLE unconditionally.
- A request withdrawn mid-transaction still completes and still pulses its hit.
- Data priority is strict; the requester must drop dmemREN/dmemWEN by the cycle after dhit, or it is re-granted.
- ihit and dhit are never high together. ramREN and ramWEN are never high together.
- ramaddr/ramstore hold their last latched value when idle.

## Timing
- All outputs registered. Reset (async): state IDLE; ihit, dhit, ramREN, ramWEN, timeout = 0; iload, dload, ramaddr, ramstore = 0.
- Request high in IDLE cycle t -> ram enable high at t+1.
- RAM ACCESS in cycle t+k (k>=1) -> hit high at t+k+1 -> IDLE at t+k+2.
- Minimum turnaround: 3 cycles request-to-next-grant; zero-wait RAM gives hit 2 cycles after request.
- RST asserted mid-transaction: immediate abort, no hit, load registers cleared.

## Configuration
- ARB_TIMEOUT_EN defined: a 10-bit counter clears on entry to IFETCH/DACCESS and increments each cycle ramstate!=ACCESS. When it reaches TIMEOUT-1 without ACCESS: go to RESP, pulse the pending hit, load the corresponding load register with 32'h0 (write: dload unchanged), set timeout. timeout stays set until RST.
- ARB_TIMEOUT_EN undefined: no counter and no timeout port; the arbiter waits indefinitely for ACCESS.

## Test plan
- Reset, then imemREN=1, imemaddr=0x100, RAM answers ACCESS same cycle with 0x3C010004 -> ramREN high 1 cycle, ihit pulses 2 cycles after the request, iload=0x3C010004.
- imemREN=1 and dmemREN=1 together, dmemaddr=0x200, ramload=0xDEADBEEF -> data granted first, dhit with dload=0xDEADBEEF. Fetch is granted 3 cycles after the data request, then ihit.
- dmemWEN=1, dmemaddr=0x80, dmemstore=0x12345678, RAM BUSY 4 cycles -> ramWEN/ramaddr/ramstore held stable 5 cycles, dhit once, dload unchanged.
- dmemREN dropped 1 cycle after grant, RAM BUSY 3 cycles -> transaction completes, dhit still pulses.
- RST asserted during a BUSY wait -> all outputs 0 the same cycle, no hit; a new fetch after release works normally.
- ARB_TIMEOUT_EN, TIMEOUT=8, ramstate stuck BUSY -> ihit after 8 wait cycles, iload=0, timeout=1 and stays 1 until RST.
